fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter: RESET_PC, 64'h0, fetch address loaded on reset; bits [1:0] SHALL be 00.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: mem_req  output  1  instruction-memory request valid.
REQ-005 Port: mem_addr  output  64  byte address of requested instruction.
REQ-006 Port: mem_ready  input  1  memory response valid for the current request.
REQ-007 Port: mem_rdata  input  32  instruction word, valid when mem_ready=1.
REQ-008 Port: redirect_valid  input  1  branch/jump redirect request, single-cycle pulse or held.
REQ-009 Port: redirect_pc  input  64  redirect target; bits [1:0] SHALL be ignored and treated as 00.
REQ-010 Port: inst_valid  output  1  held instruction is valid for decode.
REQ-011 Port: inst  output  32  fetched instruction word.
REQ-012 Port: inst_pc  output  64  address the held instruction was fetched from.
REQ-013 Port: dec_ready  input  1  decode accepts inst this cycle; handshake completes when inst_valid & dec_ready.

Function
REQ-014 FSM SHALL have exactly three states: S_IDLE, S_FETCH, S_HOLD; registered outputs only, no combinational input-to-output paths.
REQ-015 S_IDLE: mem_req=0, inst_valid=0; next state S_FETCH unconditionally.
REQ-016 S_FETCH: mem_req=1, mem_addr=pc; pc and mem_addr SHALL remain stable until mem_ready.
REQ-017 S_FETCH, mem_ready=1, no kill pending, redirect_valid=0: inst<=mem_rdata, inst_pc<=pc, pc<=pc+4 (modulo 2^64), inst_valid<=1, next S_HOLD.
REQ-018 S_FETCH, redirect_valid=1, mem_ready=0: kill<=1, pending_pc<=redirect_pc; a later redirect before response SHALL overwrite pending_pc.
REQ-019 S_FETCH, mem_ready=1 with kill=1 or redirect_valid=1: response SHALL be discarded, inst_valid stays 0, pc<=redirect_pc if redirect_valid else pending_pc, kill<=0, stay S_FETCH (new request next cycle).
REQ-020 S_HOLD: mem_req=0, inst_valid=1, inst/inst_pc held stable until handshake or redirect.
REQ-021 S_HOLD, dec_ready=1, redirect_valid=0: inst_valid<=0, next S_FETCH at pc.
REQ-022 S_HOLD, redirect_valid=1 (any dec_ready): inst_valid<=0, pc<=redirect_pc, next S_FETCH; with dec_ready=1 the handshake counts as completed.
REQ-023 S_IDLE, redirect_valid=1: pc<=redirect_pc; next S_FETCH requests the target.
REQ-024 mem_ready SHALL be ignored outside S_FETCH.
REQ-025 Minimum latency: request issued cycle N, mem_ready at N -> inst_valid=1 at N+1; sustained throughput 1 instruction per 2 cycles with zero-wait memory and dec_ready=1.
REQ-026 No instruction from a discarded response or a superseded redirect path SHALL ever present inst_valid=1.

Reset
REQ-027 reset=1 at a clock edge SHALL force: state S_IDLE, pc=RESET_PC, kill=0, pending_pc=0, mem_req=0, inst_valid=0, inst=0, inst_pc=0, regardless of state.
REQ-028 reset SHALL dominate redirect_valid, mem_ready and dec_ready in the same cycle.
REQ-029 Reset during S_FETCH SHALL abandon the outstanding request; a late mem_ready in the following S_IDLE cycle SHALL be ignored.

Verification
REQ-030 Reset release, mem_ready=1 always, dec_ready=1 -> mem_addr sequence 0x0,0x4,0x8 on successive S_FETCH cycles; inst_pc matches each.
REQ-031 Fetch at 0x10, mem_ready held 0 for 3 cycles -> mem_req=1, mem_addr=0x10 stable all 3 cycles; inst_valid=1 one cycle after mem_ready.
REQ-032 dec_ready=0 for 4 cycles in S_HOLD -> inst/inst_pc unchanged, mem_req=0; on dec_ready=1 next fetch at inst_pc+4.
REQ-033 Redirect to 0x203 while request to 0x8 outstanding, response 2 cycles later -> response dropped, inst_valid stays 0, next mem_addr=0x200.
REQ-034 Redirect and dec_ready same cycle in S_HOLD -> inst_valid=0 next cycle, next mem_addr=redirect target.
REQ-035 pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next mem_addr=0x0; reset asserted mid-S_FETCH -> all outputs at reset values next cycle, first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: one outstanding memory request, a single holding
// register toward decode, and redirect handling that squashes wrong-path responses.
module fetch_controller #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        dec_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_t;

  state_t      state_reg;
  logic [63:0] pc_reg;
  logic [63:0] pending_pc_reg;
  logic        kill_reg;
  logic        mem_req_reg;
  logic        inst_valid_reg;
  logic [31:0] inst_reg;
  logic [63:0] inst_pc_reg;
  logic [63:0] redirect_target;

  // Targets are always word aligned; the low two bits of the request are dropped.
  assign redirect_target = redirect_pc & ~64'h3;

  // The request address is the pc itself, which only moves once the response lands.
  assign mem_req    = mem_req_reg;
  assign mem_addr   = pc_reg;
  assign inst_valid = inst_valid_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      pc_reg         <= RESET_PC;
      pending_pc_reg <= 64'h0;
      kill_reg       <= 1'b0;
      mem_req_reg    <= 1'b0;
      inst_valid_reg <= 1'b0;
      inst_reg       <= 32'h0;
      inst_pc_reg    <= 64'h0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (redirect_valid) begin
            pc_reg <= redirect_target;
          end
          state_reg   <= S_FETCH;
          mem_req_reg <= 1'b1;
        end

        S_FETCH: begin
          if (mem_ready) begin
            if (kill_reg || redirect_valid) begin
              // Wrong-path response: drop it and re-request from the newest target.
              pc_reg   <= redirect_valid ? redirect_target : pending_pc_reg;
              kill_reg <= 1'b0;
            end else begin
              inst_reg       <= mem_rdata;
              inst_pc_reg    <= pc_reg;
              pc_reg         <= pc_reg + 64'd4;
              inst_valid_reg <= 1'b1;
              mem_req_reg    <= 1'b0;
              state_reg      <= S_HOLD;
            end
          end else if (redirect_valid) begin
            kill_reg       <= 1'b1;
            pending_pc_reg <= redirect_target;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            pc_reg         <= redirect_target;
            inst_valid_reg <= 1'b0;
            mem_req_reg    <= 1'b1;
            state_reg      <= S_FETCH;
          end else if (dec_ready) begin
            inst_valid_reg <= 1'b0;
            mem_req_reg    <= 1'b1;
            state_reg      <= S_FETCH;
          end
        end

        default: begin
          state_reg      <= S_IDLE;
          mem_req_reg    <= 1'b0;
          inst_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed boundary cases then randomized traffic, with
// expected instruction addresses queued by the driver and checked by a monitor.
module tb_fetch_controller;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        dec_ready;

  always #5 clk = ~clk;

  fetch_controller #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .dec_ready      (dec_ready)
  );

  int n_pass      = 0;
  int n_total     = 0;
  int n_presented = 0;

  // Program-order model: address of the next instruction decode must see.
  logic [63:0] exp_q[$];
  logic [63:0] last_pc = 64'h0;

  logic        p_valid = 1'b0;
  logic        p_req   = 1'b0;
  logic [63:0] p_addr  = 64'h0;
  logic [31:0] p_inst  = 32'h0;
  logic [63:0] p_pc    = 64'h0;

  function automatic logic [31:0] memfn(input logic [63:0] a);
    logic [63:0] h;
    h = a * 64'h9E37_79B9_7F4A_7C15;
    return h[63:32] ^ a[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: inputs seen here are the ones sampled at the edge just passed.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 64'h0);
      chk("rst_mem_addr", mem_addr, RESET_PC);
    end else begin
      if (inst_valid && !p_valid) begin
        n_presented++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_inst", inst_pc, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          $display("t=%0t present pc=%h inst=%h", $time, inst_pc, inst);
          chk("sb_inst_pc", inst_pc, e);
          chk("sb_inst_data", inst, memfn(e));
          last_pc = e;
        end
        chk("latency_one_cycle", p_req && mem_ready, 1'b1);
      end
      if (p_valid && !dec_ready && !redirect_valid) begin
        chk("hold_valid", inst_valid, 1'b1);
        chk("hold_inst", inst, p_inst);
        chk("hold_pc", inst_pc, p_pc);
      end
      if (p_req && !mem_ready) begin
        chk("req_stable", mem_req, 1'b1);
        chk("addr_stable", mem_addr, p_addr);
      end
      if (inst_valid) chk("no_req_in_hold", mem_req, 1'b0);
    end
    p_valid = inst_valid;
    p_req   = mem_req;
    p_addr  = mem_addr;
    p_inst  = inst;
    p_pc    = inst_pc;
  end

  // Drive one cycle of inputs and advance the program-order model accordingly.
  task automatic step(input logic rst, input logic rv, input logic [63:0] rpc,
                      input logic dr, input logic mr);
    @(negedge clk);
    #1;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = dr;
    mem_ready      = mr;
    mem_rdata      = mr ? memfn(mem_addr) : $urandom;
    if (rst) exp_q = {RESET_PC};
    else if (rv) exp_q = {rpc & ~64'h3};
    else if (inst_valid && dr) exp_q = {last_pc + 64'd4};
  endtask

  initial begin
    logic [63:0] seen[$];
    logic [63:0] tgt;
    int          base;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
    dec_ready = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    exp_q = {RESET_PC};
    repeat (3) step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

    // Zero-wait memory, always-ready decode: sequential fetch addresses.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
      if (mem_req) seen.push_back(mem_addr);
    end
    chk("seq_count", seen.size() >= 3, 1'b1);
    if (seen.size() >= 3)
      for (int i = 0; i < 3; i++) chk("seq_addr", seen[i], 64'(4 * i));

    // Memory wait states at 0x10.
    step(1'b0, 1'b1, 64'h10, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      chk("wait_req", mem_req, 1'b1);
      chk("wait_addr", mem_addr, 64'h10);
    end
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);

    // Decode stall for four cycles, then next fetch at 0x14.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 64'h0, 1'b0, 1'($urandom % 2));
      chk("stall_req", mem_req, 1'b0);
      chk("stall_pc", inst_pc, 64'h10);
    end
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("after_stall_addr", mem_addr, 64'h14);

    // Redirect to 0x203 while the request to 0x8 is outstanding.
    step(1'b0, 1'b1, 64'h8, 1'b1, 1'b1);
    step(1'b0, 1'b1, 64'h203, 1'b1, 1'b0);
    chk("kill_orig_addr", mem_addr, 64'h8);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("kill_valid", inst_valid, 1'b0);
    chk("kill_new_addr", mem_addr, 64'h200);

    // Redirect together with dec_ready while holding.
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 64'h400, 1'b1, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("hold_redir_valid", inst_valid, 1'b0);
    chk("hold_redir_addr", mem_addr, 64'h400);

    // Address wrap at the top of the space.
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("wrap_addr", mem_addr, 64'h0);

    // Reset mid-fetch dominates every other input; late response ignored.
    step(1'b1, 1'b1, 64'h300, 1'b1, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("post_rst_req", mem_req, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("post_rst_addr", mem_addr, RESET_PC);
    chk("post_rst_req2", mem_req, 1'b1);

    // Randomized traffic.
    base = n_presented;
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom % 4 == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1023));
      step(1'($urandom % 200 == 0), 1'($urandom % 8 == 0), tgt,
           1'($urandom % 3 != 0), 1'($urandom % 2));
    end
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("liveness", (n_presented - base) >= 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
